// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit: FSM states,
// funct3 access-size encodings, strobe generation and load data extension.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    // A 32-bit datapath has no double access; it degrades to a word.
    function automatic logic [1:0] eff_size(input logic [2:0] funct3, input int xlen);
        return (xlen == 32 && funct3[1:0] == SIZE_D) ? SIZE_W : funct3[1:0];
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off,
                                           input int strb_w);
        return (int'(off) + (1 << size)) > strb_w;
    endfunction

    // Strobes are built 8 bits wide so lanes shifted past the bus drop off.
    function automatic logic [7:0] strb_gen(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] strb;
        case (size)
            SIZE_B:  strb = 8'h01 << off;
            SIZE_H:  strb = 8'h03 << off;
            SIZE_W:  strb = 8'h0F << off;
            default: strb = 8'hFF;
        endcase
        return strb;
    endfunction

    function automatic logic [63:0] load_extend(input logic [63:0] rdata, input logic [2:0] off,
                                                input logic [2:0] funct3);
        logic [63:0] sh;
        logic [63:0] res;
        sh = rdata >> {off, 3'b000};
        case (funct3[1:0])
            SIZE_B:  res = funct3[2] ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            SIZE_H:  res = funct3[2] ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            SIZE_W:  res = funct3[2] ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic for the LSU: byte strobes, store data placement
// and load data extraction with sign/zero extension.
module mem_align
    import mem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STRB_W = XLEN / 8,
    parameter int OFF_W  = $clog2(STRB_W)
) (
    input  logic [OFF_W-1:0]  off,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   rdata,
    output logic [STRB_W-1:0] strb,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   load_data
);

    logic [1:0] size;

    always_comb begin
        size      = eff_size(funct3, XLEN);
        strb      = STRB_W'(strb_gen(size, 3'(off)));
        wdata     = store_data << {off, 3'b000};
        load_data = XLEN'(load_extend(64'(rdata), 3'(off), {funct3[2], size}));
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// EX->MEM load/store stage with a req/gnt/rvalid data-memory port.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of issuing them.
module mem_stage_lsu
    import mem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] calculated_adr,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   pc_plus_4_ex,
    input  logic [XLEN-1:0]   regfileb_ex,
    input  logic              cw_branch_taken,
    input  logic              cw_rf_wb,
    input  logic              cw_mem_we,
    input  logic              cw_mem_re,
    input  logic              cw_pc_src,
    input  logic [1:0]        cw_wb_src,
    input  logic [2:0]        cw_funct3,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [STRB_W-1:0] dmem_strb,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              stall,
    output logic [ADDR_W-1:0] target_pc,
    output logic              pc_src_mem,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              misalign_trap,
`endif
    output logic              mem_valid,
    output logic [XLEN-1:0]   mem_data_out,
    output logic [XLEN-1:0]   alu_result_mem,
    output logic [XLEN-1:0]   pc_plus_4_mem,
    output logic [3:0]        control_word_mem
);

    localparam int OFF_W = $clog2(STRB_W);

    lsu_state_e        state_q, state_d;
    logic              mem_valid_q, mem_valid_d;
    logic [XLEN-1:0]   mem_data_q, mem_data_d;
    logic [XLEN-1:0]   alu_result_q, alu_result_d;
    logic [XLEN-1:0]   pc_plus_4_q, pc_plus_4_d;
    logic [3:0]        cw_q, cw_d;
    logic [OFF_W-1:0]  off;
    logic [XLEN-1:0]   load_data;
    logic              access, mem_access, trap, capture, advance;

    assign off        = calculated_adr[OFF_W-1:0];
    assign access     = ex_valid & (cw_mem_we | cw_mem_re);
    assign target_pc  = calculated_adr;
    assign pc_src_mem = cw_branch_taken & cw_pc_src & ex_valid;
    assign dmem_addr  = {calculated_adr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign dmem_we    = mem_access & cw_mem_we;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;
    logic trap_q;
    assign misaligned    = is_misaligned(eff_size(cw_funct3, XLEN), 3'(off), STRB_W);
    assign trap          = access & misaligned;
    assign mem_access    = access & ~misaligned;
    assign misalign_trap = trap_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) trap_q <= 1'b0;
        else     trap_q <= trap;
    end
`else
    assign trap       = 1'b0;
    assign mem_access = access;
`endif

    mem_align #(.XLEN(XLEN), .STRB_W(STRB_W), .OFF_W(OFF_W)) u_align (
        .off        (off),
        .funct3     (cw_funct3),
        .store_data (regfileb_ex),
        .rdata      (dmem_rdata),
        .strb       (dmem_strb),
        .wdata      (dmem_wdata),
        .load_data  (load_data)
    );

    // A grant and response in the same cycle complete the access immediately.
    always_comb begin
        state_d  = state_q;
        dmem_req = 1'b0;
        capture  = 1'b0;
        case (state_q)
            IDLE, REQ: begin
                if (mem_access) begin
                    dmem_req = 1'b1;
                    if (dmem_gnt && dmem_rvalid) begin
                        capture = 1'b1;
                        state_d = IDLE;
                    end else if (dmem_gnt) begin
                        state_d = WAIT_RSP;
                    end else begin
                        state_d = REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_RSP: begin
                if (dmem_rvalid) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall   = mem_access & ~capture;
    assign advance = capture | (ex_valid & ~access) | trap;

    always_comb begin
        mem_valid_d  = advance;
        mem_data_d   = mem_data_q;
        alu_result_d = alu_result_q;
        pc_plus_4_d  = pc_plus_4_q;
        cw_d         = cw_q;
        if (advance) begin
            mem_data_d   = (capture && !cw_mem_we) ? load_data : '0;
            alu_result_d = alu_result;
            pc_plus_4_d  = pc_plus_4_ex;
            cw_d         = {cw_rf_wb & ~trap, cw_wb_src, pc_src_mem};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_valid_q  <= 1'b0;
            mem_data_q   <= '0;
            alu_result_q <= '0;
            pc_plus_4_q  <= '0;
            cw_q         <= '0;
        end else begin
            state_q      <= state_d;
            mem_valid_q  <= mem_valid_d;
            mem_data_q   <= mem_data_d;
            alu_result_q <= alu_result_d;
            pc_plus_4_q  <= pc_plus_4_d;
            cw_q         <= cw_d;
        end
    end

    assign mem_valid        = mem_valid_q;
    assign mem_data_out     = mem_data_q;
    assign alu_result_mem   = alu_result_q;
    assign pc_plus_4_mem    = pc_plus_4_q;
    assign control_word_mem = cw_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed scoreboard bench for mem_stage_lsu (XLEN=32); also covers the
// MEM_MISALIGN_TRAP_EN build when that macro is defined.
module tb_mem_stage_lsu;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;
    localparam int STRB_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_valid;
    logic [ADDR_W-1:0] calculated_adr;
    logic [XLEN-1:0]   alu_result, pc_plus_4_ex, regfileb_ex;
    logic              cw_branch_taken, cw_rf_wb, cw_mem_we, cw_mem_re, cw_pc_src;
    logic [1:0]        cw_wb_src;
    logic [2:0]        cw_funct3;
    logic              dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [ADDR_W-1:0] dmem_addr, target_pc;
    logic [XLEN-1:0]   dmem_wdata, dmem_rdata;
    logic [STRB_W-1:0] dmem_strb;
    logic              stall, pc_src_mem, mem_valid;
    logic [XLEN-1:0]   mem_data_out, alu_result_mem, pc_plus_4_mem;
    logic [3:0]        control_word_mem;
`ifdef MEM_MISALIGN_TRAP_EN
    logic              misalign_trap;
`endif

    mem_stage_lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid         (ex_valid),
        .calculated_adr   (calculated_adr),
        .alu_result       (alu_result),
        .pc_plus_4_ex     (pc_plus_4_ex),
        .regfileb_ex      (regfileb_ex),
        .cw_branch_taken  (cw_branch_taken),
        .cw_rf_wb         (cw_rf_wb),
        .cw_mem_we        (cw_mem_we),
        .cw_mem_re        (cw_mem_re),
        .cw_pc_src        (cw_pc_src),
        .cw_wb_src        (cw_wb_src),
        .cw_funct3        (cw_funct3),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_strb        (dmem_strb),
        .dmem_gnt         (dmem_gnt),
        .dmem_rvalid      (dmem_rvalid),
        .dmem_rdata       (dmem_rdata),
        .stall            (stall),
        .target_pc        (target_pc),
        .pc_src_mem       (pc_src_mem),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_trap    (misalign_trap),
`endif
        .mem_valid        (mem_valid),
        .mem_data_out     (mem_data_out),
        .alu_result_mem   (alu_result_mem),
        .pc_plus_4_mem    (pc_plus_4_mem),
        .control_word_mem (control_word_mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [3:0]  cw;
        logic        trap;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic drive_idle();
        ex_valid        = 1'b0;
        cw_mem_we       = 1'b0;
        cw_mem_re       = 1'b0;
        cw_branch_taken = 1'b0;
        cw_pc_src       = 1'b0;
        dmem_gnt        = 1'b0;
        dmem_rvalid     = 1'b0;
    endtask

    // One EX instruction: the memory model grants gnt_delay cycles after issue
    // and responds rsp_delay cycles after the grant (0 = same cycle).
    task automatic applyStimulus(input logic [31:0] adr, input logic we, input logic re,
                                 input logic [2:0] f3, input logic [31:0] store_data,
                                 input logic rf_wb, input logic [1:0] wb_src,
                                 input logic branch, input logic [31:0] alu,
                                 input logic exp_req, input logic [3:0] exp_strb,
                                 input logic [31:0] exp_wdata, input int gnt_delay,
                                 input int rsp_delay, input logic [31:0] rdata,
                                 input logic [31:0] exp_data, input logic exp_trap);
        exp_t e;
        exp_t got;
        int   hold    = 0;
        int   gcyc    = 0;
        bit   granted = 1'b0;
        bit   done    = 1'b0;
        bit   gnt_now, rv_now;
        int   exp_hold;

        ex_valid        = 1'b1;
        calculated_adr  = adr;
        cw_mem_we       = we;
        cw_mem_re       = re;
        cw_funct3       = f3;
        regfileb_ex     = store_data;
        cw_rf_wb        = rf_wb;
        cw_wb_src       = wb_src;
        cw_branch_taken = branch;
        cw_pc_src       = branch;
        alu_result      = alu;
        pc_plus_4_ex    = alu + 32'd4;
        dmem_rdata      = rdata;

        e.data = exp_data;
        e.alu  = alu;
        e.pc4  = alu + 32'd4;
        e.cw   = {rf_wb & ~exp_trap, wb_src, branch};
        e.trap = exp_trap;
        exp_q.push_back(e);

        for (int c = 0; c < 40 && !done; c++) begin
            gnt_now = exp_req && !granted && (c == gnt_delay);
            if (gnt_now) gcyc = c;
            rv_now = exp_req && (granted || gnt_now) && (c == gcyc + rsp_delay);
            dmem_gnt    = gnt_now;
            dmem_rvalid = rv_now;
            #1;
            if (c == 0) begin
                checkOutput("req_issue", dmem_req, exp_req);
                checkOutput("target_pc", target_pc, adr);
                checkOutput("pc_src_mem", pc_src_mem, branch);
                if (exp_req) begin
                    checkOutput("dmem_we", dmem_we, we);
                    checkOutput("dmem_strb", dmem_strb, exp_strb);
                    checkOutput("dmem_wdata", dmem_wdata, exp_wdata);
                    checkOutput("dmem_addr", dmem_addr, {adr[31:2], 2'b00});
                end
            end else if (!granted) begin
                checkOutput("req_held", dmem_req, 1'b1);
                checkOutput("addr_held", dmem_addr, {adr[31:2], 2'b00});
                checkOutput("strb_held", dmem_strb, exp_strb);
            end else begin
                checkOutput("req_wait_low", dmem_req, 1'b0);
            end
            hold++;
            done = (stall === 1'b0);
            if (gnt_now) granted = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) checkOutput("stall_timeout", 64'd0, 64'd1);
        drive_idle();

        exp_hold = exp_req ? gnt_delay + rsp_delay + 1 : 1;
        checkOutput("ex_hold_cycles", hold, exp_hold);
        checkOutput("mem_valid", mem_valid, 1'b1);
        if (mem_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("sb_underflow", 64'd0, 64'd1);
            end else begin
                got = exp_q.pop_front();
                checkOutput("mem_data_out", mem_data_out, got.data);
                checkOutput("alu_result_mem", alu_result_mem, got.alu);
                checkOutput("pc_plus_4_mem", pc_plus_4_mem, got.pc4);
                checkOutput("control_word_mem", control_word_mem, got.cw);
`ifdef MEM_MISALIGN_TRAP_EN
                checkOutput("misalign_trap", misalign_trap, got.trap);
`endif
            end
        end
        @(posedge clk);
        #1;
        checkOutput("mem_valid_single", mem_valid, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_mem_valid"}, mem_valid, 1'b0);
        checkOutput({tag, "_mem_data"}, mem_data_out, 32'd0);
        checkOutput({tag, "_alu"}, alu_result_mem, 32'd0);
        checkOutput({tag, "_pc4"}, pc_plus_4_mem, 32'd0);
        checkOutput({tag, "_cw"}, control_word_mem, 4'd0);
        checkOutput({tag, "_req"}, dmem_req, 1'b0);
        checkOutput({tag, "_stall"}, stall, 1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        calculated_adr = '0;
        alu_result     = '0;
        pc_plus_4_ex   = '0;
        regfileb_ex    = '0;
        cw_rf_wb       = 1'b0;
        cw_wb_src      = 2'b00;
        cw_funct3      = 3'b000;
        dmem_rdata     = '0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // adr, we, re, f3, sdata, rf_wb, wb_src, br, alu, req, strb, wdata, gd, rd, rdata, exp, trap
        applyStimulus(32'h400, 0, 0, 3'b000, 32'h0, 1, 2'b10, 1, 32'h1234,
                      0, 4'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        applyStimulus(32'h100, 1, 0, 3'b010, 32'hDEADBEEF, 0, 2'b00, 0, 32'h100,
                      1, 4'hF, 32'hDEADBEEF, 0, 1, 32'h0, 32'h0, 0);
        applyStimulus(32'h103, 1, 0, 3'b000, 32'h000000A5, 0, 2'b00, 0, 32'h103,
                      1, 4'b1000, 32'hA5000000, 0, 1, 32'h11111111, 32'h0, 0);
        applyStimulus(32'h106, 1, 0, 3'b001, 32'h0000BEEF, 0, 2'b00, 0, 32'h106,
                      1, 4'b1100, 32'hBEEF0000, 1, 1, 32'h0, 32'h0, 0);
        applyStimulus(32'h102, 0, 1, 3'b000, 32'h0, 1, 2'b01, 0, 32'h102,
                      1, 4'b0100, 32'h0, 0, 1, 32'h0080FF00, 32'hFFFFFF80, 0);
        applyStimulus(32'h102, 0, 1, 3'b100, 32'h0, 1, 2'b01, 0, 32'h102,
                      1, 4'b0100, 32'h0, 0, 1, 32'h0080FF00, 32'h00000080, 0);
        applyStimulus(32'h102, 0, 1, 3'b001, 32'h0, 1, 2'b01, 0, 32'h202,
                      1, 4'b1100, 32'h0, 3, 2, 32'h80010000, 32'hFFFF8001, 0);
        applyStimulus(32'h108, 0, 1, 3'b010, 32'h0, 1, 2'b01, 0, 32'h108,
                      1, 4'hF, 32'h0, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 0);
        applyStimulus(32'h104, 0, 1, 3'b011, 32'h0, 1, 2'b01, 0, 32'h104,
                      1, 4'hF, 32'h0, 0, 1, 32'h80000001, 32'h80000001, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        applyStimulus(32'h102, 0, 1, 3'b010, 32'h0, 1, 2'b01, 0, 32'h302,
                      0, 4'h0, 32'h0, 0, 0, 32'hAABBCCDD, 32'h0, 1);
`else
        applyStimulus(32'h102, 0, 1, 3'b010, 32'h0, 1, 2'b01, 0, 32'h302,
                      1, 4'b1100, 32'h0, 0, 1, 32'hAABBCCDD, 32'h0000AABB, 0);
`endif

        // Reset while waiting for the response; the late rvalid must be ignored.
        ex_valid       = 1'b1;
        calculated_adr = 32'h200;
        cw_mem_re      = 1'b1;
        cw_funct3      = 3'b010;
        cw_rf_wb       = 1'b1;
        alu_result     = 32'h777;
        pc_plus_4_ex   = 32'h77B;
        dmem_gnt       = 1'b1;
        #1;
        checkOutput("rst_txn_req", dmem_req, 1'b1);
        @(posedge clk);
        #1;
        drive_idle();
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk);
        #1;
        rst         = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5A5A5A5A;
        #1;
        checkOutput("late_rvalid_req", dmem_req, 1'b0);
        checkOutput("late_rvalid_stall", stall, 1'b0);
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b0;
        check_all_zero("late_rvalid");

        applyStimulus(32'h10C, 0, 1, 3'b110, 32'h0, 1, 2'b01, 0, 32'h10C,
                      1, 4'hF, 32'h0, 0, 1, 32'hF0000000, 32'hF0000000, 0);

        checkOutput("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
